// File: rtl/bram_dma_copy_pkg.sv
// Shared definitions for the BRAM DMA copy engine: FSM state encoding and write-mask constants.
package bram_dma_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [3:0] WMASK_ALL  = 4'hf;
    localparam logic [3:0] WMASK_NONE = 4'h0;

endpackage

// File: rtl/bram_dma_copy_if.sv
// BRAM word port plus arbiter request/grant, as seen by the DMA (master) and the BRAM/arbiter side (slave).
interface bram_dma_copy_if #(parameter int WIDTH = 8);

    logic             bus_req;
    logic             bus_gnt;
    logic [WIDTH-1:0] bram_addr;
    logic [31:0]      bram_wdata;
    logic [3:0]       bram_wmask;
    logic [31:0]      bram_rdata;

    modport master (
        output bus_req, bram_addr, bram_wdata, bram_wmask,
        input  bus_gnt, bram_rdata
    );

    modport slave (
        input  bus_req, bram_addr, bram_wdata, bram_wmask,
        output bus_gnt, bram_rdata
    );

endinterface

// File: rtl/bram_dma_ctr.sv
// Loadable down-counter for the remaining word count; zero flag marks the last word.
module bram_dma_ctr #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/bram_dma_copy.sv
// BRAM-internal word copy engine (optional word fill when BRAM_DMA_FILL_EN is defined).
//   state  | meaning
//   IDLE   | waiting for start
//   RD     | source address on the port, waiting for grant
//   LAT    | read data returning, captured into data_q
//   WR     | destination write beat, advances on grant
//   DONE   | one-cycle done pulse
module bram_dma_copy
    import bram_dma_copy_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WIDTH-1:0]  src_addr,
    input  logic [WIDTH-1:0]  dst_addr,
    input  logic [WIDTH:0]    len,
`ifdef BRAM_DMA_FILL_EN
    input  logic              fill,
    input  logic [31:0]       fill_data,
`endif
    output logic              busy,
    output logic              done,
    bram_dma_copy_if.master   bus
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  src_q, src_d;
    logic [WIDTH-1:0]  dst_q, dst_d;
    logic [31:0]       data_q, data_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
`ifdef BRAM_DMA_FILL_EN
    logic              fill_q, fill_d;
    logic [31:0]       fill_data_q, fill_data_d;
`endif

    logic              cnt_load;
    logic [WIDTH:0]    cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;

    // Counter holds words remaining minus one, so zero means the current write is the last.
    bram_dma_ctr #(.W(WIDTH + 1)) u_ctr (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        data_d       = data_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef BRAM_DMA_FILL_EN
        fill_d       = fill_q;
        fill_data_d  = fill_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d        = src_addr;
                    dst_d        = dst_addr;
                    cnt_load     = 1'b1;
                    cnt_load_val = (len == '0) ? '0 : len - 1'b1;
`ifdef BRAM_DMA_FILL_EN
                    fill_d       = fill;
                    fill_data_d  = fill_data;
                    if (len == '0)  state_d = S_DONE;
                    else if (fill)  state_d = S_WR;
                    else            state_d = S_RD;
`else
                    state_d      = (len == '0) ? S_DONE : S_RD;
`endif
                end
            end
            S_RD: begin
                if (bus.bus_gnt) state_d = S_LAT;
            end
            S_LAT: begin
                data_d  = bus.bram_rdata;
                state_d = S_WR;
            end
            S_WR: begin
                if (bus.bus_gnt) begin
                    src_d = src_q + 1'b1;
                    dst_d = dst_q + 1'b1;
                    if (cnt_zero) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_dec = 1'b1;
`ifdef BRAM_DMA_FILL_EN
                        state_d = fill_q ? S_WR : S_RD;
`else
                        state_d = S_RD;
`endif
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Port outputs are precomputed from the next state so they leave flops directly.
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = WMASK_NONE;
        if (state_d == S_RD) begin
            addr_d = src_d;
        end else if (state_d == S_WR) begin
            addr_d  = dst_d;
            wmask_d = WMASK_ALL;
`ifdef BRAM_DMA_FILL_EN
            wdata_d = fill_d ? fill_data_d : data_d;
`else
            wdata_d = data_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= WMASK_NONE;
`ifdef BRAM_DMA_FILL_EN
            fill_q      <= 1'b0;
            fill_data_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
`ifdef BRAM_DMA_FILL_EN
            fill_q      <= fill_d;
            fill_data_q <= fill_data_d;
`endif
        end
    end

    assign busy           = (state_q == S_RD) || (state_q == S_LAT) || (state_q == S_WR);
    assign done           = (state_q == S_DONE);
    assign bus.bus_req    = busy;
    assign bus.bram_addr  = addr_q;
    assign bus.bram_wdata = wdata_q;
    assign bus.bram_wmask = wmask_q;

endmodule

// File: tb/tb_bram_dma_copy.sv
// Bench for bram_dma_copy: BRAM + random-grant arbiter model, reference copy model feeding a scoreboard.
module tb_bram_dma_copy;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  src_addr, dst_addr;
    logic [8:0]  len;
    logic        busy, done;
`ifdef BRAM_DMA_FILL_EN
    logic        fill;
    logic [31:0] fill_data;
`endif

    bram_dma_copy_if #(.WIDTH(8)) bus ();

    bram_dma_copy #(.WIDTH(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
`ifdef BRAM_DMA_FILL_EN
        .fill      (fill),
        .fill_data (fill_data),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int gnt_pct = 100;
    int done_seen = 0;

    logic [31:0] mem    [256];
    logic [31:0] refmem [256];
    logic [39:0] wq[$];
    int          dq[$];

    // BRAM with arbiter: port only reaches the memory in granted cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.bus_gnt) begin
            bus.bram_rdata <= mem[bus.bram_addr];
            if (bus.bram_wmask == 4'hf) mem[bus.bram_addr] = bus.bram_wdata;
        end else begin
            bus.bram_rdata <= $urandom;
        end
    end

    always @(negedge clk) bus.bus_gnt = ($urandom_range(99) < gnt_pct);

    // Monitor / scoreboard
    always @(negedge clk) begin
        #2;
        if (resetn) begin
            checks++;
            if (bus.bus_req !== busy) begin
                failures++;
                $display("FAIL bus_req: got %b want %b (busy)", bus.bus_req, busy);
            end
            if (bus.bram_wmask !== 4'h0) begin
                checks++;
                if (!busy || bus.bram_wmask !== 4'hf) begin
                    failures++;
                    $display("FAIL wmask_state: wmask %h busy %b want wmask f only while busy", bus.bram_wmask, busy);
                end
            end
            if (bus.bram_wmask === 4'hf && bus.bus_gnt) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", bus.bram_addr, bus.bram_wdata);
                end else begin
                    logic [39:0] e;
                    e = wq.pop_front();
                    if ({bus.bram_addr, bus.bram_wdata} !== e) begin
                        failures++;
                        $display("FAIL write_beat: got addr %h data %h want addr %h data %h",
                                 bus.bram_addr, bus.bram_wdata, e[39:32], e[31:0]);
                    end
                end
            end
            if (done) begin
                checks++;
                if (dq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    int el;
                    el = dq.pop_front();
                    if (busy !== 1'b0) begin
                        failures++;
                        $display("FAIL busy_at_done: got %b want 0", busy);
                    end
                    if (el >= 0 && (cyc - start_cyc) != el) begin
                        failures++;
                        $display("FAIL done_latency: got %0d want %0d", cyc - start_cyc, el);
                    end
                end
                done_seen++;
            end
        end
    end

    task automatic ref_op(input logic [7:0] s, input logic [7:0] d, input int n,
                          input bit f, input logic [31:0] fd);
        for (int i = 0; i < n; i++) begin
            logic [7:0]  a;
            logic [31:0] v;
            a = d + 8'(i);
            v = f ? fd : refmem[8'(s + 8'(i))];
            refmem[a] = v;
            wq.push_back({a, v});
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        int first = -1;
        checks++;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== refmem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (bad != 0) begin
            failures++;
            $display("FAIL mem_%s: %0d words differ, first addr %h got %h want %h",
                     name, bad, first, mem[first], refmem[first]);
        end
    endtask

    task automatic check_queues(input string name);
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            failures++;
            $display("FAIL queues_%s: %0d writes and %0d dones outstanding, want 0", name, wq.size(), dq.size());
        end
        wq.delete();
        dq.delete();
    endtask

    task automatic run_op(input string name, input logic [7:0] s, input logic [7:0] d, input int n,
                          input bit f, input logic [31:0] fd, input bit inject);
        int t = 0;
        int ds;
        ref_op(s, d, n, f, fd);
        if (gnt_pct < 100) dq.push_back(-1);
        else if (n == 0)   dq.push_back(1);
        else if (f)        dq.push_back(n + 1);
        else               dq.push_back(3 * n + 1);
        ds = done_seen;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = 9'(n); start = 1'b1; start_cyc = cyc;
`ifdef BRAM_DMA_FILL_EN
        fill = f; fill_data = fd;
`endif
        @(negedge clk);
        start = 1'b0; src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 9'($urandom);
`ifdef BRAM_DMA_FILL_EN
        fill = 1'($urandom); fill_data = $urandom;
`endif
        while (done_seen == ds && t < 4000) begin
            @(negedge clk);
            start = (inject && t == 3);
            t++;
        end
        start = 1'b0;
        if (t >= 4000) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: no done after %0d cycles, want done", name, t);
        end
        repeat (2) @(negedge clk);
        check_queues(name);
        check_mem(name);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
`ifdef BRAM_DMA_FILL_EN
        fill = 1'b0; fill_data = '0;
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hA0 + i;
        for (int i = 0; i < 256; i++) refmem[i] = mem[i];
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.bus_req !== 1'b0 || bus.bram_addr !== 8'h0 ||
            bus.bram_wdata !== 32'h0 || bus.bram_wmask !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: busy %b done %b req %b addr %h wdata %h wmask %h want all 0",
                     busy, done, bus.bus_req, bus.bram_addr, bus.bram_wdata, bus.bram_wmask);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        gnt_pct = 100;
        run_op("basic", 8'h10, 8'h40, 4, 1'b0, 32'h0, 1'b0);
        run_op("len0", 8'h55, 8'h66, 0, 1'b0, 32'h0, 1'b0);
        run_op("wrap", 8'hFE, 8'h7E, 4, 1'b0, 32'h0, 1'b0);
        run_op("overlap", 8'h80, 8'h82, 6, 1'b0, 32'h0, 1'b0);
        gnt_pct = 25;
        run_op("rgnt", 8'($urandom), 8'($urandom), 16, 1'b0, 32'h0, 1'b0);
        gnt_pct = 100;
        run_op("full", 8'h00, 8'h00, 256, 1'b0, 32'h0, 1'b0);

        // Reset while the fourth of eight words is on the port.
        begin
            int beats = 0;
            int t = 0;
            ref_op(8'h30, 8'hA0, 3, 1'b0, 32'h0);
            @(negedge clk);
            src_addr = 8'h30; dst_addr = 8'hA0; len = 9'd8; start = 1'b1; start_cyc = cyc;
            @(negedge clk);
            start = 1'b0;
            while (resetn && t < 100) begin
                #1;
                if (bus.bram_wmask === 4'hf && bus.bus_gnt) begin
                    if (beats == 3) resetn = 1'b0;
                    else beats++;
                end
                if (resetn) @(negedge clk);
                t++;
            end
            #1;
            checks++;
            if (resetn !== 1'b0 || bus.bram_wmask !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || bus.bus_req !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset: resetn %b wmask %h busy %b done %b req %b want reset applied, outputs 0",
                         resetn, bus.bram_wmask, busy, done, bus.bus_req);
            end
            repeat (2) @(negedge clk);
            resetn = 1'b1;
            repeat (30) @(negedge clk);
            check_queues("mid_reset");
            check_mem("mid_reset");
        end

`ifdef BRAM_DMA_FILL_EN
        run_op("fill", 8'h00, 8'h20, 3, 1'b1, 32'hDEADBEEF, 1'b0);
        run_op("fill0", 8'h00, 8'h90, 0, 1'b1, 32'h12345678, 1'b0);
        gnt_pct = 40;
        run_op("fill_rgnt", 8'($urandom), 8'($urandom), 12, 1'b1, $urandom, 1'b0);
        gnt_pct = 100;
`endif

        for (int k = 0; k < 8; k++) begin
            int n;
            int p;
            bit f;
            n = $urandom_range(24, 3);
            p = $urandom_range(2);
            gnt_pct = (p == 0) ? 100 : ((p == 1) ? 60 : 25);
            f = 1'b0;
`ifdef BRAM_DMA_FILL_EN
            f = 1'($urandom);
`endif
            run_op("rand", 8'($urandom), 8'($urandom), n, f, $urandom, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
